// File: rtl/async_sram_pkg.sv
// Shared encodings, defaults and helpers for the async SRAM controller.
package async_sram_pkg;

  localparam int unsigned N_SRAM_A_DEF     = 18;
  localparam int unsigned READ_LATENCY_DEF = 2;
  localparam int unsigned N_DQ             = 16;
  localparam int unsigned N_BUS            = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Request fields still needed after the accept cycle.
  typedef struct packed {
    logic            write;
    logic            is_word;
    logic            is_byte;
    logic [1:0]      addr_lo;
    logic [N_DQ-1:0] wdata_hi;
  } req_t;

  // Registered PHY control bundle; dq_oe is expanded to all lanes at the port.
  typedef struct packed {
    logic            ce_n;
    logic            we_n;
    logic            oe_n;
    logic [1:0]      byte_n;
    logic            dq_oe;
    logic [N_DQ-1:0] dq_out;
  } phy_t;

  localparam phy_t PHY_IDLE = '{
    ce_n:   1'b1,
    we_n:   1'b1,
    oe_n:   1'b1,
    byte_n: 2'b11,
    dq_oe:  1'b0,
    dq_out: 16'h0000
  };

  // Strobes, lane enables and write data for the first halfword phase.
  function automatic phy_t phase0_ctrl(input logic             write,
                                       input logic [1:0]       size,
                                       input logic [1:0]       addr_lo,
                                       input logic [N_BUS-1:0] wdata);
    phy_t p;
    p      = PHY_IDLE;
    p.ce_n = 1'b0;
    if (write) begin
      p.we_n  = 1'b0;
      p.dq_oe = 1'b1;
    end else begin
      p.oe_n = 1'b0;
    end
    if (size == SIZE_BYTE) p.byte_n = ~(2'b01 << addr_lo[0]);
    else                   p.byte_n = 2'b00;
    if (size[1])         p.dq_out = wdata[15:0];
    else if (addr_lo[1]) p.dq_out = wdata[31:16];
    else                 p.dq_out = wdata[15:0];
    return p;
  endfunction

  // Builds the bus read word from the final halfword and the captured low half.
  function automatic logic [N_BUS-1:0] assemble_rdata(input req_t            r,
                                                      input logic [N_DQ-1:0] hw,
                                                      input logic [N_DQ-1:0] lo);
    logic [7:0] b;
    b = r.addr_lo[0] ? hw[15:8] : hw[7:0];
    if (r.is_word)      return {hw, lo};
    else if (r.is_byte) return {4{b}};
    else                return {2{hw}};
  endfunction

endpackage

// File: rtl/async_sram_rdata_pipe.sv
// Tag delay line that lines up each issued read halfword with ctrl_dq_in.
module async_sram_rdata_pipe
  import async_sram_pkg::*;
#(
  parameter int unsigned READ_LATENCY = READ_LATENCY_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            push_phase,
  input  logic [N_DQ-1:0] dq_in,
  output logic            cap_valid,
  output logic            cap_phase,
  output logic [N_DQ-1:0] lo
);

  logic [READ_LATENCY-1:0] vld_sr;
  logic [READ_LATENCY-1:0] ph_sr;

  // Tag pushed after the issue cycle reaches the tail when the data is on dq_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr <= '0;
      ph_sr  <= '0;
      lo     <= '0;
    end else begin
      vld_sr <= {vld_sr[READ_LATENCY-2:0], push};
      ph_sr  <= {ph_sr[READ_LATENCY-2:0], push_phase};
      if (vld_sr[READ_LATENCY-1] && !ph_sr[READ_LATENCY-1]) lo <= dq_in;
    end
  end

  assign cap_valid = vld_sr[READ_LATENCY-1];
  assign cap_phase = ph_sr[READ_LATENCY-1];

endmodule

// File: rtl/async_sram_ctrl.sv
// Bus-side controller for a 16-bit async SRAM: splits bus requests into
// registered halfword PHY cycles and returns one response per request.
module async_sram_ctrl
  import async_sram_pkg::*;
#(
  parameter int unsigned N_SRAM_A     = N_SRAM_A_DEF,
  parameter int unsigned N_SRAM_DQ    = N_DQ,
  parameter int unsigned READ_LATENCY = READ_LATENCY_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic [N_SRAM_A:0]    req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  output logic [31:0]          resp_rdata,
  output logic [N_SRAM_A-1:0]  ctrl_addr,
  output logic [N_SRAM_DQ-1:0] ctrl_dq_out,
  output logic [N_SRAM_DQ-1:0] ctrl_dq_oe,
  input  logic [N_SRAM_DQ-1:0] ctrl_dq_in,
  output logic                 ctrl_ce_n,
  output logic                 ctrl_we_n,
  output logic                 ctrl_oe_n,
  output logic [1:0]           ctrl_byte_n
);

  logic [1:0]          state, state_d;
  logic                phase, phase_d;
  req_t                req_q, req_d;
  phy_t                phy_q, phy_d;
  logic [N_SRAM_A-1:0] addr_q, addr_d;
  logic                ready_d;
  logic                resp_valid_d;
  logic [31:0]         rdata_d;
  logic                push;
  logic                cap_valid;
  logic                cap_phase;
  logic [N_DQ-1:0]     lo_q;

  async_sram_rdata_pipe #(
    .READ_LATENCY (READ_LATENCY)
  ) u_rdata_pipe (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_phase (phase),
    .dq_in      (ctrl_dq_in),
    .cap_valid  (cap_valid),
    .cap_phase  (cap_phase),
    .lo         (lo_q)
  );

  // State and every port-facing output are flops; reset drops all strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      phase      <= 1'b0;
      req_q      <= '0;
      phy_q      <= PHY_IDLE;
      addr_q     <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state      <= state_d;
      phase      <= phase_d;
      req_q      <= req_d;
      phy_q      <= phy_d;
      addr_q     <= addr_d;
      req_ready  <= ready_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= rdata_d;
    end
  end

  // Next state plus the next value of each registered output.
  always_comb begin
    state_d      = state;
    phase_d      = phase;
    req_d        = req_q;
    phy_d        = PHY_IDLE;
    phy_d.dq_out = phy_q.dq_out;
    addr_d       = addr_q;
    resp_valid_d = 1'b0;
    rdata_d      = resp_rdata;
    push         = 1'b0;

    case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          req_d.write    = req_write;
          req_d.is_word  = req_size[1];
          req_d.is_byte  = (req_size == SIZE_BYTE);
          req_d.addr_lo  = req_addr[1:0];
          req_d.wdata_hi = req_wdata[31:16];
          phy_d          = phase0_ctrl(req_write, req_size, req_addr[1:0], req_wdata);
          addr_d         = req_size[1] ? {req_addr[N_SRAM_A:2], 1'b0}
                                       : req_addr[N_SRAM_A:1];
          phase_d        = 1'b0;
          state_d        = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        push = !req_q.write;
        if (req_q.is_word && !phase) begin
          // Second halfword keeps the strobes and moves to the odd index.
          phase_d      = 1'b1;
          phy_d        = phy_q;
          phy_d.dq_out = req_q.wdata_hi;
          addr_d       = {addr_q[N_SRAM_A-1:1], 1'b1};
        end else if (req_q.write) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (cap_valid && (cap_phase == req_q.is_word)) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b1;
          rdata_d      = assemble_rdata(req_q, ctrl_dq_in, lo_q);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  assign ctrl_addr   = addr_q;
  assign ctrl_dq_out = phy_q.dq_out;
  assign ctrl_dq_oe  = {N_SRAM_DQ{phy_q.dq_oe}};
  assign ctrl_ce_n   = phy_q.ce_n;
  assign ctrl_we_n   = phy_q.we_n;
  assign ctrl_oe_n   = phy_q.oe_n;
  assign ctrl_byte_n = phy_q.byte_n;

endmodule

// File: tb/tb_async_sram_ctrl.sv
// Directed bench for async_sram_ctrl with a behavioural SRAM+PHY model per instance.
module tb_async_sram_ctrl;
  import async_sram_pkg::*;

  localparam int unsigned NA   = 18;
  localparam int unsigned RL_A = 2;
  localparam int unsigned RL_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic          req_valid, req_ready, req_write;
  logic [1:0]    req_size;
  logic [NA:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic [NA-1:0] ctrl_addr;
  logic [15:0]   ctrl_dq_out, ctrl_dq_oe, ctrl_dq_in;
  logic          ctrl_ce_n, ctrl_we_n, ctrl_oe_n;
  logic [1:0]    ctrl_byte_n;

  logic          req_valid_b, req_ready_b, req_write_b;
  logic [1:0]    req_size_b;
  logic [NA:0]   req_addr_b;
  logic [31:0]   req_wdata_b;
  logic          resp_valid_b;
  logic [31:0]   resp_rdata_b;
  logic [NA-1:0] ctrl_addr_b;
  logic [15:0]   ctrl_dq_out_b, ctrl_dq_oe_b, ctrl_dq_in_b;
  logic          ctrl_ce_n_b, ctrl_we_n_b, ctrl_oe_n_b;
  logic [1:0]    ctrl_byte_n_b;

  int n_checks = 0;
  int n_errors = 0;

  async_sram_ctrl #(.N_SRAM_A(NA), .N_SRAM_DQ(16), .READ_LATENCY(RL_A)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .ctrl_addr(ctrl_addr), .ctrl_dq_out(ctrl_dq_out), .ctrl_dq_oe(ctrl_dq_oe),
    .ctrl_dq_in(ctrl_dq_in), .ctrl_ce_n(ctrl_ce_n), .ctrl_we_n(ctrl_we_n),
    .ctrl_oe_n(ctrl_oe_n), .ctrl_byte_n(ctrl_byte_n)
  );

  async_sram_ctrl #(.N_SRAM_A(NA), .N_SRAM_DQ(16), .READ_LATENCY(RL_B)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write_b),
    .req_size(req_size_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b),
    .ctrl_addr(ctrl_addr_b), .ctrl_dq_out(ctrl_dq_out_b), .ctrl_dq_oe(ctrl_dq_oe_b),
    .ctrl_dq_in(ctrl_dq_in_b), .ctrl_ce_n(ctrl_ce_n_b), .ctrl_we_n(ctrl_we_n_b),
    .ctrl_oe_n(ctrl_oe_n_b), .ctrl_byte_n(ctrl_byte_n_b)
  );

  // SRAM + PHY models: byte-lane writes, reads returned RL cycles after issue.
  logic [15:0] mem_a [64];
  logic [15:0] pipe_a [RL_A];
  logic [15:0] mem_b [64];
  logic [15:0] pipe_b [RL_B];

  always @(posedge clk) begin
    if (!ctrl_ce_n && !ctrl_we_n) begin
      if (!ctrl_byte_n[0]) mem_a[ctrl_addr[5:0]][7:0]  <= ctrl_dq_out[7:0];
      if (!ctrl_byte_n[1]) mem_a[ctrl_addr[5:0]][15:8] <= ctrl_dq_out[15:8];
    end
    pipe_a[0] <= (!ctrl_ce_n && !ctrl_oe_n) ? mem_a[ctrl_addr[5:0]] : 16'hDEAD;
    for (int k = 1; k < RL_A; k++) pipe_a[k] <= pipe_a[k-1];
  end
  assign ctrl_dq_in = pipe_a[RL_A-1];

  always @(posedge clk) begin
    if (!ctrl_ce_n_b && !ctrl_we_n_b) begin
      if (!ctrl_byte_n_b[0]) mem_b[ctrl_addr_b[5:0]][7:0]  <= ctrl_dq_out_b[7:0];
      if (!ctrl_byte_n_b[1]) mem_b[ctrl_addr_b[5:0]][15:8] <= ctrl_dq_out_b[15:8];
    end
    pipe_b[0] <= (!ctrl_ce_n_b && !ctrl_oe_n_b) ? mem_b[ctrl_addr_b[5:0]] : 16'hDEAD;
    for (int k = 1; k < RL_B; k++) pipe_b[k] <= pipe_b[k-1];
  end
  assign ctrl_dq_in_b = pipe_b[RL_B-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ce_n"},   32'(ctrl_ce_n),   32'd1);
    check({tag, "_we_n"},   32'(ctrl_we_n),   32'd1);
    check({tag, "_oe_n"},   32'(ctrl_oe_n),   32'd1);
    check({tag, "_byte_n"}, 32'(ctrl_byte_n), 32'd3);
    check({tag, "_dq_oe"},  32'(ctrl_dq_oe),  32'd0);
  endtask

  task automatic check_issue(input string tag, input logic [NA-1:0] a, input logic wr,
                             input logic [1:0] bn, input logic [15:0] dq);
    check({tag, "_addr"},   32'(ctrl_addr),   32'(a));
    check({tag, "_ce_n"},   32'(ctrl_ce_n),   32'd0);
    check({tag, "_we_n"},   32'(ctrl_we_n),   32'(!wr));
    check({tag, "_oe_n"},   32'(ctrl_oe_n),   32'(wr));
    check({tag, "_byte_n"}, 32'(ctrl_byte_n), 32'(bn));
    check({tag, "_dq_oe"},  32'(ctrl_dq_oe),  wr ? 32'h0000_FFFF : 32'd0);
    if (wr) check({tag, "_dq_out"}, 32'(ctrl_dq_out), 32'(dq));
  endtask

  // Accepts at cycle A; returns at the middle of A+1 with inputs scrambled.
  task automatic start(input logic wr, input logic [1:0] sz, input logic [NA:0] a,
                       input logic [31:0] wd);
    @(negedge clk);
    check("ready_before_accept", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_write = !wr; req_size = SIZE_BYTE; req_addr = ~a; req_wdata = ~wd;
  endtask

  // From cycle A+cur, expects the single response pulse at A+at.
  task automatic expect_resp(input string tag, input int cur, input int at,
                             input logic chk_data, input logic [31:0] rd);
    for (int k = cur + 1; k <= at; k++) begin
      @(negedge clk);
      if (k < at) check({tag, "_no_early_resp"}, 32'(resp_valid), 32'd0);
    end
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    check({tag, "_ready"},      32'(req_ready),  32'd1);
    if (chk_data) check({tag, "_rdata"}, resp_rdata, rd);
    @(negedge clk);
    check({tag, "_resp_pulse"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    int last_oe, first_oe, first_we, resp_k;
    logic [31:0] rdata_b;

    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = SIZE_BYTE; req_addr = '0; req_wdata = '0;
    req_valid_b = 1'b0; req_write_b = 1'b0; req_size_b = SIZE_BYTE; req_addr_b = '0;
    req_wdata_b = '0;
    repeat (3) @(negedge clk);
    check_idle("rst");
    check("rst_addr",   32'(ctrl_addr),   32'd0);
    check("rst_dq_out", 32'(ctrl_dq_out), 32'd0);
    check("rst_resp",   32'(resp_valid),  32'd0);
    check("rst_rdata",  resp_rdata,       32'd0);
    check("rst_ready",  32'(req_ready),   32'd1);
    check("rst_b_oe_n", 32'(ctrl_oe_n_b), 32'd1);
    rst = 1'b0;

    // Halfword write in the upper lane.
    start(1'b1, SIZE_HALF, 19'h00006, 32'hBEEF_1234);
    check_issue("hw_wr", 18'h00003, 1'b1, 2'b00, 16'hBEEF);
    expect_resp("hw_wr", 1, 2, 1'b0, 32'd0);

    // Word write, low half first.
    start(1'b1, SIZE_WORD, 19'h00010, 32'h9ABC_5678);
    check_issue("w_wr0", 18'h00008, 1'b1, 2'b00, 16'h5678);
    @(negedge clk);
    check_issue("w_wr1", 18'h00009, 1'b1, 2'b00, 16'h9ABC);
    expect_resp("w_wr", 2, 3, 1'b0, 32'd0);

    start(1'b1, SIZE_HALF, 19'h00002, 32'hA55A_0000);
    check_issue("hw_wr2", 18'h00001, 1'b1, 2'b00, 16'hA55A);
    expect_resp("hw_wr2", 1, 2, 1'b0, 32'd0);

    // Word read: two issues, response at A+5 for RL=2.
    start(1'b0, SIZE_WORD, 19'h00010, 32'd0);
    check_issue("w_rd0", 18'h00008, 1'b0, 2'b00, 16'h0);
    @(negedge clk);
    check_issue("w_rd1", 18'h00009, 1'b0, 2'b00, 16'h0);
    @(negedge clk);
    check_idle("w_rd_wait");
    expect_resp("w_rd", 3, 5, 1'b1, 32'h9ABC_5678);

    start(1'b0, SIZE_BYTE, 19'h00003, 32'd0);
    check_issue("b_rd", 18'h00001, 1'b0, 2'b01, 16'h0);
    expect_resp("b_rd", 1, 4, 1'b1, 32'hA5A5_A5A5);

    start(1'b0, SIZE_HALF, 19'h00006, 32'd0);
    check_issue("hw_rd", 18'h00003, 1'b0, 2'b00, 16'h0);
    expect_resp("hw_rd", 1, 4, 1'b1, 32'hBEEF_BEEF);

    // Size 3 behaves as word and misaligned low bits are dropped.
    start(1'b0, 2'd3, 19'h00013, 32'd0);
    check_issue("mis_rd0", 18'h00008, 1'b0, 2'b00, 16'h0);
    @(negedge clk);
    check_issue("mis_rd1", 18'h00009, 1'b0, 2'b00, 16'h0);
    expect_resp("mis_rd", 2, 5, 1'b1, 32'h9ABC_5678);

    // Byte write to the upper byte of halfword 2, then read it back.
    start(1'b1, SIZE_BYTE, 19'h00005, 32'h1111_CD22);
    check_issue("b_wr", 18'h00002, 1'b1, 2'b01, 16'hCD22);
    expect_resp("b_wr", 1, 2, 1'b0, 32'd0);
    start(1'b0, SIZE_BYTE, 19'h00005, 32'd0);
    check_issue("b_rd2", 18'h00002, 1'b0, 2'b01, 16'h0);
    expect_resp("b_rd2", 1, 4, 1'b1, 32'hCDCD_CDCD);

    // Top-of-memory word write must not wrap.
    start(1'b1, SIZE_WORD, 19'h7FFFC, 32'hCAFE_F00D);
    check_issue("top_wr0", 18'h3FFFE, 1'b1, 2'b00, 16'hF00D);
    @(negedge clk);
    check_issue("top_wr1", 18'h3FFFF, 1'b1, 2'b00, 16'hCAFE);
    expect_resp("top_wr", 2, 3, 1'b0, 32'd0);

    // Reset held three cycles in the middle of a word write.
    start(1'b1, SIZE_WORD, 19'h00020, 32'h1111_2222);
    check_issue("rst_wr", 18'h00010, 1'b1, 2'b00, 16'h2222);
    rst = 1'b1;
    @(negedge clk);
    check_idle("rst_mid");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rst_mid_no_resp", 32'(resp_valid), 32'd0);
      check("rst_mid_ready",   32'(req_ready),  32'd1);
    end

    // Reset while a read is waiting for data drops the response.
    start(1'b0, SIZE_HALF, 19'h00006, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rst_rd_no_resp", 32'(resp_valid), 32'd0);
    end
    start(1'b0, SIZE_HALF, 19'h00006, 32'd0);
    check_issue("post_rst_rd", 18'h00003, 1'b0, 2'b00, 16'h0);
    expect_resp("post_rst_rd", 1, 4, 1'b1, 32'hBEEF_BEEF);

    // RL=3 instance: preload halfword 2, then a read with a write right behind it.
    @(negedge clk);
    req_valid_b = 1'b1; req_write_b = 1'b1; req_size_b = SIZE_HALF;
    req_addr_b = 19'h00004; req_wdata_b = 32'h0000_1357;
    @(negedge clk);
    req_valid_b = 1'b0;
    resp_k = -1;
    for (int k = 1; k < 10; k++) begin
      if (resp_valid_b && resp_k < 0) resp_k = k;
      @(negedge clk);
    end
    check("b_pre_resp_cycle", 32'(resp_k), 32'd2);

    check("b_ready", 32'(req_ready_b), 32'd1);
    req_valid_b = 1'b1; req_write_b = 1'b0; req_size_b = SIZE_HALF; req_addr_b = 19'h00004;
    @(negedge clk);
    req_write_b = 1'b1; req_wdata_b = 32'h0000_2468;
    last_oe = -1; first_oe = -1; first_we = -1; resp_k = -1; rdata_b = '0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 1) check("b_rd_addr", 32'(ctrl_addr_b), 32'd2);
      if (!ctrl_oe_n_b) last_oe = k;
      if (ctrl_dq_oe_b != 16'h0 && first_oe < 0) first_oe = k;
      if (!ctrl_we_n_b && first_we < 0) begin
        first_we = k;
        req_valid_b = 1'b0;
      end
      if (resp_valid_b && resp_k < 0) begin
        resp_k  = k;
        rdata_b = resp_rdata_b;
      end
      @(negedge clk);
    end
    check("b_rd_resp_cycle", 32'(resp_k),   32'd5);
    check("b_rd_rdata",      rdata_b,       32'h1357_1357);
    check("b_last_oe",       32'(last_oe),  32'd1);
    check("b_first_dq_oe",   32'(first_oe), 32'd6);
    check("b_first_we",      32'(first_we), 32'd6);
    check("b_wr_after_resp", 32'(first_we > resp_k), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
